mux2x1_arbiter: RTL

- Round-robin arbiter that shares one 2:1 mux output path between two requesters.
- Accepts per-requester request lines and issues one-hot registered grants.
- Drives the mux select to match the current grant.
- Bounds each tenure to MAX_BURST cycles, so a continuously requesting source cannot starve the other.

---
 rtl/mux2x1_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mux2x1_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux path between two requesters.
// Grants are one-hot and registered, and each tenure is capped at MAX_BURST cycles while the other side waits.
module mux2x1_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   output logic [1:0]       gnt,
   output logic             sel,
   output logic             busy,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             switch_pulse
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] BEAT_MAX  = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] BEAT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] BEAT_ZERO = CNT_W'(0);

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic             sel_q, sel_d;
   logic             sw_q, sw_d;
   logic             busy_q, busy_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [CNT_W-1:0] beat_q, beat_d;

   logic             idx_s, oth_idx_s, own_s, oth_s;
   logic             enter_s, enter_idx_s, go_idle_s, inc_s;

   // Next-state decision: enter a tenure, extend it, or fall back to idle.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      sel_d       = sel_q;
      beat_d      = beat_q;
      sw_d        = 1'b0;
      enter_s     = 1'b0;
      enter_idx_s = 1'b0;
      go_idle_s   = 1'b0;
      inc_s       = 1'b0;
      idx_s       = (state_q == G1);
      oth_idx_s   = ~idx_s;
      own_s       = req[idx_s];
      oth_s       = req[oth_idx_s];

      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               enter_s     = 1'b1;
               enter_idx_s = (req == 2'b11) ? ~last_q : req[1];
            end else begin
               go_idle_s = 1'b0;
            end
         end
         G0, G1: begin
            if (own_s && (beat_q != BEAT_MAX)) begin
               inc_s = 1'b1;
            end else if (oth_s) begin
               // Early release or forced rotation: hand over with no idle gap.
               enter_s     = 1'b1;
               enter_idx_s = oth_idx_s;
               sw_d        = 1'b1;
            end else if (own_s) begin
               enter_s     = 1'b1;
               enter_idx_s = idx_s;
            end else begin
               go_idle_s = 1'b1;
            end
         end
         default: begin
            go_idle_s = 1'b1;
         end
      endcase

      if (enter_s) begin
         state_d = enter_idx_s ? G1 : G0;
         beat_d  = BEAT_ONE;
         last_d  = enter_idx_s;
         sel_d   = enter_idx_s;
      end else if (go_idle_s) begin
         state_d = IDLE;
         beat_d  = BEAT_ZERO;
      end else if (inc_s) begin
         beat_d = beat_q + BEAT_ONE;
      end else begin
         state_d = state_q;
         beat_d  = beat_q;
      end

      gnt_d  = {state_d == G1, state_d == G0};
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset drops the grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         sel_q   <= 1'b0;
         sw_q    <= 1'b0;
         busy_q  <= 1'b0;
         gnt_q   <= 2'b00;
         beat_q  <= BEAT_ZERO;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         sw_q    <= sw_d;
         busy_q  <= busy_d;
         gnt_q   <= gnt_d;
         beat_q  <= beat_d;
      end
   end

   assign gnt          = gnt_q;
   assign sel          = sel_q;
   assign busy         = busy_q;
   assign beat_cnt     = beat_q;
   assign switch_pulse = sw_q;

endmodule
